// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, BRAM read port, 2-deep output buffer, redirect flush
// Optional MISALIGN_TRAP_EN: misaligned redirect raises sticky misalign_fault and halts fetch.
module instr_fetch #(
    parameter int          ADDR_WIDTH = 7,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    output logic                  mem_read_enable,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_data,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
`ifdef MISALIGN_TRAP_EN
    output logic                  misalign_fault,
`endif
    output logic [31:0]           out_instr,
    output logic [31:0]           out_pc
);

    logic [31:0] pc;
    logic [31:0] fetch_pc;
    logic        inflight;
    logic [31:0] inflight_pc;
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;
    logic [1:0]  occ;
    logic        consume;
    logic        resp;
    logic        halted;

    always_comb begin
        fetch_pc = redirect_valid ? (redirect_pc & ~32'd3) : pc;
        consume  = out_valid & out_ready;
        occ      = {1'b0, out_valid} + {1'b0, skid_valid} + {1'b0, inflight};
`ifdef MISALIGN_TRAP_EN
        halted   = misalign_fault | (redirect_valid & (redirect_pc[1:0] != 2'b00));
`else
        halted   = 1'b0;
`endif
        // A redirect flushes all storage, so its target may always issue.
        mem_read_enable = reset_n & ~halted
                        & (redirect_valid | ((occ - {1'b0, consume}) < 2'd2));
        mem_addr = fetch_pc[ADDR_WIDTH+1:2];
        // The response returning during a redirect belongs to the old stream.
        resp     = inflight & ~redirect_valid;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            skid_valid  <= 1'b0;
            skid_instr  <= 32'h0;
            skid_pc     <= 32'h0;
            out_valid   <= 1'b0;
            out_instr   <= 32'h0;
            out_pc      <= 32'h0;
        end else begin
            if (mem_read_enable) begin
                pc <= fetch_pc + 32'd4;
            end
            inflight    <= mem_read_enable;
            inflight_pc <= fetch_pc;

            if (redirect_valid) begin
                out_valid  <= 1'b0;
                skid_valid <= 1'b0;
            end else if (!out_valid || consume) begin
                if (skid_valid) begin
                    out_valid  <= 1'b1;
                    out_instr  <= skid_instr;
                    out_pc     <= skid_pc;
                    skid_valid <= resp;
                    if (resp) begin
                        skid_instr <= mem_data;
                        skid_pc    <= inflight_pc;
                    end
                end else if (resp) begin
                    out_valid <= 1'b1;
                    out_instr <= mem_data;
                    out_pc    <= inflight_pc;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (resp) begin
                // Output is stalled; the issue rule guarantees the skid is free.
                skid_valid <= 1'b1;
                skid_instr <= mem_data;
                skid_pc    <= inflight_pc;
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            misalign_fault <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misalign_fault <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch (honours MISALIGN_TRAP_EN)
module tb_instr_fetch;

    localparam int AW = 7;

    logic          clock;
    logic          reset_n;
    logic          mem_read_enable;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data;
    logic          redirect_valid;
    logic [31:0]   redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic [31:0]   out_pc;
`ifdef MISALIGN_TRAP_EN
    logic          misalign_fault;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] expq[$];

    instr_fetch #(.ADDR_WIDTH(AW), .RESET_PC(32'h0)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .mem_read_enable(mem_read_enable),
        .mem_addr(mem_addr),
        .mem_data(mem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef MISALIGN_TRAP_EN
        .misalign_fault(misalign_fault),
`endif
        .out_instr(out_instr),
        .out_pc(out_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous BRAM: word k holds 0x1000_0000 + k.
    always @(posedge clock) begin
        if (mem_read_enable) mem_data <= 32'h1000_0000 + 32'(mem_addr);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return 32'h1000_0000 + ((pc >> 2) & 32'h7F);
    endfunction

    // Scoreboard: redirects/reset seed the expected PC stream, handshakes consume it.
    always @(negedge clock) begin
        if (!reset_n) begin
            expq.delete();
            expq.push_back(32'h0);
        end else begin
            if (out_valid && out_ready) begin
                logic [31:0] e;
                e = (expq.size() > 0) ? expq.pop_front() : ~out_pc;
                check_eq("sb_pc", out_pc, e);
                check_eq("sb_instr", out_instr, instr_of(e));
                if (expq.size() == 0) expq.push_back(e + 32'd4);
            end
            if (redirect_valid) begin
                expq.delete();
`ifdef MISALIGN_TRAP_EN
                if (redirect_pc[1:0] == 2'b00) expq.push_back(redirect_pc);
`else
                expq.push_back(redirect_pc & ~32'd3);
`endif
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic redirect_to(input logic [31:0] target);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = target;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_eq("rst_valid", 32'(out_valid), 32'd0);
        check_eq("rst_pc", out_pc, 32'h0);
        check_eq("rst_instr", out_instr, 32'h0);
        check_eq("rst_rd_en", 32'(mem_read_enable), 32'd0);

        // 1: first valid two cycles after release
        step(); reset_n = 1'b1;
        @(negedge clock);
        check_eq("c0_rd_en", 32'(mem_read_enable), 32'd1);
        check_eq("c0_addr", 32'(mem_addr), 32'd0);
        check_eq("c0_valid", 32'(out_valid), 32'd0);
        step(); @(negedge clock);
        check_eq("c1_valid", 32'(out_valid), 32'd0);
        step(); @(negedge clock);
        check_eq("c2_valid", 32'(out_valid), 32'd1);
        check_eq("c2_pc", out_pc, 32'h0);

        // 2: stall 5 cycles on the 2nd valid
        step(); out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check_eq("stall_valid", 32'(out_valid), 32'd1);
            check_eq("stall_pc", out_pc, 32'h4);
            check_eq("stall_instr", out_instr, 32'h1000_0001);
            check_eq("stall_rd_en", 32'(mem_read_enable), 32'd0);
            step();
        end
        out_ready = 1'b1;
        repeat (6) step();

        // 3: redirect while streaming; coincident handshake still counts
        redirect_to(32'h40);
        @(negedge clock);
        check_eq("rd3_addr", 32'(mem_addr), 32'h10);
        check_eq("rd3_rd_en", 32'(mem_read_enable), 32'd1);
        check_eq("rd3_hs_valid", 32'(out_valid), 32'd1);
        step(); redirect_valid = 1'b0;
        @(negedge clock);
        check_eq("rd3_r1_valid", 32'(out_valid), 32'd0);
        step(); @(negedge clock);
        check_eq("rd3_r2_valid", 32'(out_valid), 32'd1);
        check_eq("rd3_r2_pc", out_pc, 32'h40);
        repeat (3) step();

        // 4: stalled then redirect with handshake, then back-to-back redirect
        out_ready = 1'b0;
        repeat (3) step();
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h80;
        @(negedge clock);
        check_eq("rd4_hs_valid", 32'(out_valid), 32'd1);
        redirect_to(32'hC0);
        @(negedge clock);
        check_eq("rd4_b2b_addr", 32'(mem_addr), 32'h30);
        step(); redirect_valid = 1'b0;
        @(negedge clock);
        check_eq("rd4_r1_valid", 32'(out_valid), 32'd0);
        step(); @(negedge clock);
        check_eq("rd4_r2_pc", out_pc, 32'hC0);
        repeat (3) step();

        // 5: BRAM address wrap
        redirect_to(32'h1FC);
        @(negedge clock);
        check_eq("wrap_addr0", 32'(mem_addr), 32'd127);
        step(); redirect_valid = 1'b0;
        @(negedge clock);
        check_eq("wrap_addr1", 32'(mem_addr), 32'd0);
        step(); @(negedge clock);
        check_eq("wrap_pc0", out_pc, 32'h1FC);
        step(); @(negedge clock);
        check_eq("wrap_pc1", out_pc, 32'h200);
        check_eq("wrap_instr1", out_instr, 32'h1000_0000);
        repeat (2) step();

        // 6: misaligned redirect
        redirect_to(32'h42);
        @(negedge clock);
`ifdef MISALIGN_TRAP_EN
        check_eq("mis_rd_en", 32'(mem_read_enable), 32'd0);
        step(); redirect_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            check_eq("mis_fault", 32'(misalign_fault), 32'd1);
            check_eq("mis_valid", 32'(out_valid), 32'd0);
            step();
        end
        reset_n = 1'b0;
        @(negedge clock);
        check_eq("mis_fault_clr", 32'(misalign_fault), 32'd0);
        step(); reset_n = 1'b1;
        repeat (2) step();
        @(negedge clock);
        check_eq("mis_restart_pc", out_pc, 32'h0);
        check_eq("mis_restart_valid", 32'(out_valid), 32'd1);
`else
        check_eq("mis_addr", 32'(mem_addr), 32'h10);
        step(); redirect_valid = 1'b0;
        step(); @(negedge clock);
        check_eq("mis_pc", out_pc, 32'h40);
        check_eq("mis_valid", 32'(out_valid), 32'd1);
`endif
        repeat (4) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
